// File: rtl/ex_issue_if.sv
// Decode / execute handshake bundle for the EX issue controller.
// The controller side uses the slave modport; the decode / functional-unit
// environment side uses the master modport.
interface ex_issue_if #(
  parameter int unsigned RD_W = 5
) ();

  // Decode handshake
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      op_class_i;
  logic [RD_W-1:0] rd_i;
  logic            flush_i;

  // Multiplier handshake
  logic            mul_start_o;
  logic            mul_done_i;

  // Load handshake
  logic            ld_req_o;
  logic            ld_ack_i;

  // Result-select strobes and tag
  logic            ctrl_addsub_o;
  logic            ctrl_mul_o;
  logic            ctrl_shift_o;
  logic            ctrl_logic_o;
  logic            ctrl_ld_o;
  logic            ctrl_br_o;
  logic [RD_W-1:0] wb_rd_o;

  // Error pulses
  logic            err_illegal_o;
  logic            err_timeout_o;

  modport slave (
    input  valid_i, op_class_i, rd_i, flush_i, mul_done_i, ld_ack_i,
    output ready_o, mul_start_o, ld_req_o,
    output ctrl_addsub_o, ctrl_mul_o, ctrl_shift_o, ctrl_logic_o,
    output ctrl_ld_o, ctrl_br_o, wb_rd_o,
    output err_illegal_o, err_timeout_o
  );

  modport master (
    output valid_i, op_class_i, rd_i, flush_i, mul_done_i, ld_ack_i,
    input  ready_o, mul_start_o, ld_req_o,
    input  ctrl_addsub_o, ctrl_mul_o, ctrl_shift_o, ctrl_logic_o,
    input  ctrl_ld_o, ctrl_br_o, wb_rd_o,
    input  err_illegal_o, err_timeout_o
  );

endinterface

// File: rtl/ex_issue_ctrl.sv
// EX issue controller.
// Accepts one decoded op per valid/ready handshake and produces one-hot
// result-select strobes for the EX result register. Single-cycle classes
// issue with latency 1; multiply and load park the controller in a wait
// state (ready low) until the unit completes, a load times out, or a flush.
// All outputs come straight from registers.
module ex_issue_ctrl #(
  parameter int unsigned LD_TIMEOUT = 64,  // legal range 2..255
  parameter int unsigned RD_W       = 5    // must match the interface RD_W
) (
  input  logic      clk,
  input  logic      rst,                   // synchronous, active-low
  ex_issue_if.slave bus
);

  // Op class encoding; the class number doubles as the strobe bit index.
  localparam logic [2:0] CLS_ADDSUB = 3'd0;
  localparam logic [2:0] CLS_MUL    = 3'd1;
  localparam logic [2:0] CLS_SHIFT  = 3'd2;
  localparam logic [2:0] CLS_LOGIC  = 3'd3;
  localparam logic [2:0] CLS_LD     = 3'd4;
  localparam logic [2:0] CLS_BR     = 3'd5;

  localparam int unsigned NUM_SEL = 6;

  // Last counter value of a load before it is declared timed out.
  localparam logic [7:0] CNT_LAST = 8'(LD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    LD_WAIT  = 2'd2
  } state_t;

  state_t               state_reg;
  logic [7:0]           cnt_reg;
  logic [RD_W-1:0]      tag_reg;
  logic [RD_W-1:0]      wb_rd_reg;
  logic [NUM_SEL-1:0]   sel_reg;
  logic                 mul_start_reg;
  logic                 ld_req_reg;
  logic                 err_illegal_reg;
  logic                 err_timeout_reg;

  // One-hot decode of the presented class; bit index equals class number.
  logic [NUM_SEL-1:0]   class_onehot;

  generate
    for (genvar gi = 0; gi < NUM_SEL; gi++) begin : g_class_dec
      assign class_onehot[gi] = (bus.op_class_i == 3'(gi));
    end
  endgenerate

  logic accept;
  assign accept = bus.valid_i && (state_reg == IDLE);

  // Main sequencer: state, load timeout counter, latched tag and all outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      tag_reg         <= '0;
      wb_rd_reg       <= '0;
      sel_reg         <= '0;
      mul_start_reg   <= 1'b0;
      ld_req_reg      <= 1'b0;
      err_illegal_reg <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      // Strobes and pulses last one cycle unless re-asserted below.
      sel_reg         <= '0;
      mul_start_reg   <= 1'b0;
      err_illegal_reg <= 1'b0;
      err_timeout_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          // A flush in the acceptance cycle discards the op entirely.
          // Stray mul_done_i / ld_ack_i are not looked at here.
          if (accept && !bus.flush_i) begin
            case (bus.op_class_i)
              CLS_ADDSUB, CLS_SHIFT, CLS_LOGIC, CLS_BR: begin
                sel_reg   <= class_onehot;
                wb_rd_reg <= bus.rd_i;
              end
              CLS_MUL: begin
                mul_start_reg <= 1'b1;
                tag_reg       <= bus.rd_i;
                state_reg     <= MUL_WAIT;
              end
              CLS_LD: begin
                ld_req_reg <= 1'b1;
                cnt_reg    <= '0;
                tag_reg    <= bus.rd_i;
                state_reg  <= LD_WAIT;
              end
              default: begin
                err_illegal_reg <= 1'b1;
              end
            endcase
          end
        end

        MUL_WAIT: begin
          // A done pulse in the same cycle as our start pulse cannot belong
          // to this op (the multiplier has at least one cycle of latency).
          if (bus.flush_i) begin
            state_reg <= IDLE;
          end else if (bus.mul_done_i && !mul_start_reg) begin
            sel_reg[CLS_MUL] <= 1'b1;
            wb_rd_reg        <= tag_reg;
            state_reg        <= IDLE;
          end
        end

        LD_WAIT: begin
          // Priority: flush, then ack, then timeout.
          if (bus.flush_i) begin
            ld_req_reg <= 1'b0;
            state_reg  <= IDLE;
          end else if (bus.ld_ack_i) begin
            sel_reg[CLS_LD] <= 1'b1;
            wb_rd_reg       <= tag_reg;
            ld_req_reg      <= 1'b0;
            state_reg       <= IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            err_timeout_reg <= 1'b1;
            ld_req_reg      <= 1'b0;
            state_reg       <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end

        default: begin
          ld_req_reg <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  // Output mapping from registered state.
  assign bus.ready_o       = (state_reg == IDLE);
  assign bus.mul_start_o   = mul_start_reg;
  assign bus.ld_req_o      = ld_req_reg;
  assign bus.ctrl_addsub_o = sel_reg[CLS_ADDSUB];
  assign bus.ctrl_mul_o    = sel_reg[CLS_MUL];
  assign bus.ctrl_shift_o  = sel_reg[CLS_SHIFT];
  assign bus.ctrl_logic_o  = sel_reg[CLS_LOGIC];
  assign bus.ctrl_ld_o     = sel_reg[CLS_LD];
  assign bus.ctrl_br_o     = sel_reg[CLS_BR];
  assign bus.wb_rd_o       = wb_rd_reg;
  assign bus.err_illegal_o = err_illegal_reg;
  assign bus.err_timeout_o = err_timeout_reg;

endmodule

// File: doc/ex_issue_ctrl.md
Name: ex_issue_ctrl

Overview:
Sits between decode and the execute functional units and produces the one-hot per-unit result-select strobes that the EX result register consumes. It accepts one decoded op per handshake and sequences it through single-cycle units or the multi-cycle multiplier and load paths. It applies back-pressure to decode while a multi-cycle op is outstanding. It also supervises loads with a timeout and supports a flush.

Parameters:
LD_TIMEOUT, 64, cycles to wait for ld_ack_i before aborting the load; legal range 2..255.
RD_W, 5, width of the destination register tag.

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous reset, active-low
valid_i  in  1  decode presents an op
ready_o  out  1  issue controller can accept; op accepted when valid_i && ready_o
op_class_i  in  3  0 addsub, 1 mul, 2 shift, 3 logic, 4 ld, 5 br, 6/7 illegal
rd_i  in  RD_W  destination tag of the presented op
flush_i  in  1  abort any accepted but not completed op
mul_start_o  out  1  one-cycle start pulse to the multiplier
mul_done_i  in  1  multiplier result valid, one-cycle pulse
ld_req_o  out  1  load request, level, held until ack, timeout or flush
ld_ack_i  in  1  load data valid, one-cycle pulse
ctrl_addsub_o, ctrl_mul_o, ctrl_shift_o, ctrl_logic_o, ctrl_ld_o, ctrl_br_o  out  1 each  one-hot result-select strobes
wb_rd_o  out  RD_W  tag of the op whose strobe is asserted, otherwise holds the last value
err_illegal_o  out  1  one-cycle pulse on acceptance of class 6/7
err_timeout_o  out  1  one-cycle pulse when a load times out

Behaviour:
- States: IDLE, MUL_WAIT, LD_WAIT. ready_o = (state == IDLE). All outputs are registered.
- Reset (rst == 0 at a clock edge):
  - state = IDLE.
  - All strobes, mul_start_o, ld_req_o and err_* = 0.
  - wb_rd_o = 0, timeout counter = 0.
  - Reset overrides everything, including mid-multiply or mid-load. No strobe follows.
- Acceptance in IDLE (valid_i = 1, ready_o = 1):
  - Class 0/2/3/5: the matching strobe is 1 on the next cycle only, with wb_rd_o = rd_i. Latency is 1 and state stays IDLE, so back-to-back single-cycle ops issue every cycle.
  - Class 1: mul_start_o = 1 on the next cycle only, and the state goes to MUL_WAIT. The tag is latched.
  - Class 4: ld_req_o = 1 from the next cycle, the state goes to LD_WAIT, the counter is cleared to 0 and the tag is latched.
  - Class 6/7: err_illegal_o pulses on the next cycle, no strobe is asserted and the state stays IDLE.
- MUL_WAIT:
  - mul_done_i = 1 → ctrl_mul_o = 1 next cycle with the latched tag, then state = IDLE.
  - A mul_done_i in the same cycle as mul_start_o is ignored; the multiplier has at least 1 cycle of latency.
- LD_WAIT:
  - Counter increments each cycle while ld_ack_i = 0.
  - ld_ack_i = 1 → ctrl_ld_o = 1 next cycle, ld_req_o drops on that same edge, state = IDLE.
  - Counter reaching LD_TIMEOUT−1 with no ack → err_timeout_o pulses, ld_req_o drops, state = IDLE, no strobe.
  - Ack and timeout on the same cycle: the ack wins.
- flush_i = 1:
  - In MUL_WAIT/LD_WAIT → IDLE next cycle, ld_req_o = 0, no strobe, no error. A later mul_done_i or ld_ack_i arriving in IDLE is ignored.
  - flush_i with an acceptance in the same IDLE cycle: the op is discarded, no strobe.
  - flush_i with mul_done_i or ld_ack_i in the same cycle: flush wins.
- Invariants:
  - At most one ctrl_* strobe is high in any cycle.
  - mul_start_o and the ctrl strobes are never high together.
  - Stray mul_done_i / ld_ack_i pulses in IDLE have no effect.

Test Plan:
- Reset, then valid_i = 1 for 4 consecutive cycles with classes 0, 2, 3, 5 and rd 1..4 → strobes addsub, shift, logic, br on cycles 1..4, one per cycle, wb_rd_o = 1..4, ready_o stays 1.
- Class 1 with rd = 7; mul_done_i asserted 3 cycles after mul_start_o → ready_o = 0 for 4 cycles, ctrl_mul_o = 1 one cycle after done with wb_rd_o = 7, then ready_o = 1.
- Class 4 with LD_TIMEOUT = 8 and no ack → ld_req_o high for 8 cycles, err_timeout_o pulses once, no ctrl_ld_o; a late ld_ack_i is ignored.
- Class 4 with ld_ack_i on the 8th counter cycle (coinciding with timeout) → ctrl_ld_o = 1 and err_timeout_o = 0.
- Class 1 accepted, flush_i asserted 1 cycle later, then mul_done_i → no ctrl_mul_o, and ready_o = 1 the cycle after the flush.
- Class 6, then rst = 0 driven during LD_WAIT → err_illegal_o pulses once, and after reset all outputs are 0 with state IDLE.
